// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Periods are counted in cycles of the 50 MHz base clock.
package clk_div_pkg;

  localparam int CLK_BASE_FREQ = 50_000_000;
  localparam int MIN_PERIOD    = 2;
  localparam int MIN_HIGH      = 1;
  localparam int MAX_CH        = 8;

  function automatic int period_for_freq(
    input int f
  );
    return CLK_BASE_FREQ / f;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow config, clamping,
// pending flag and registered clk_out/tick.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W          = 25,
  parameter int DEFAULT_PERIOD = 50
) (
  input  logic             clk_in,
  input  logic             rst_a_n,
  input  logic             en,
  input  logic             wr,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] high,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  localparam logic [CNT_W-1:0] DEF_N =
    CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] DEF_H =
    CNT_W'(DEFAULT_PERIOD / 2);
  localparam logic [CNT_W-1:0] MIN_N =
    CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] MIN_H =
    CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] ONE =
    CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] act_n;
  logic [CNT_W-1:0] act_h;
  logic [CNT_W-1:0] sh_n;
  logic [CNT_W-1:0] sh_h;
  logic [CNT_W-1:0] wr_n;
  logic [CNT_W-1:0] wr_h;
  logic [CNT_W-1:0] nxt_n;
  logic [CNT_W-1:0] nxt_h;
  logic [CNT_W-1:0] cnt_inc;
  logic             wrap;

  // High time is clamped against the already-clamped period.
  always_comb begin
    wr_n = (period < MIN_N) ? MIN_N : period;
    wr_h = (high < MIN_H) ? MIN_H : high;
    if (wr_h >= wr_n) begin
      wr_h = wr_n - ONE;
    end
  end

  always_comb begin
    wrap    = (cnt == act_n - ONE);
    cnt_inc = cnt + ONE;
    nxt_n   = pending ? sh_n : act_n;
    nxt_h   = pending ? sh_h : act_h;
  end

  always_ff @(posedge clk_in or negedge rst_a_n) begin
    if (!rst_a_n) begin
      cnt     <= DEF_N - ONE;
      act_n   <= DEF_N;
      act_h   <= DEF_H;
      sh_n    <= DEF_N;
      sh_h    <= DEF_H;
      pending <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      if (wr) begin
        sh_n <= wr_n;
        sh_h <= wr_h;
      end
      if (en && !wrap) begin
        cnt     <= cnt_inc;
        tick    <= 1'b0;
        clk_out <= (cnt_inc < act_h);
        if (wr) begin
          pending <= 1'b1;
        end
      end else begin
        // Period boundary (or idle): safe point to adopt shadow.
        act_n   <= nxt_n;
        act_h   <= nxt_h;
        pending <= wr;
        if (en) begin
          cnt     <= '0;
          tick    <= 1'b1;
          clk_out <= (nxt_h != '0);
        end else begin
          cnt     <= nxt_n - ONE;
          tick    <= 1'b0;
          clk_out <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock/tick generator; the config
// bus is shared and decoded into per-channel write strobes.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int CNT_W          = 25,
  parameter int DEFAULT_PERIOD = 50,
  localparam int CH_W =
    (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst_a_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_high,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] cfg_pending
);

  if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_ch
    $error("clk_div_multi: NUM_CH out of range");
  end

  if (DEFAULT_PERIOD < MIN_PERIOD) begin : g_bad_def
    $error("clk_div_multi: DEFAULT_PERIOD too small");
  end

  logic [NUM_CH-1:0] wr;

  // Out-of-range channel numbers match no slot.
  always_comb begin
    wr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr[i] = cfg_we && (cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_chan #(
      .CNT_W         (CNT_W),
      .DEFAULT_PERIOD(DEFAULT_PERIOD)
    ) u_chan (
      .clk_in (clk_in),
      .rst_a_n(rst_a_n),
      .en     (en[g]),
      .wr     (wr[g]),
      .period (cfg_period),
      .high   (cfg_high),
      .clk_out(clk_out[g]),
      .tick   (tick[g]),
      .pending(cfg_pending[g])
    );
  end

endmodule
